// File: rtl/fir_coe_loader.sv
// Run-time FIR coefficient loader: streams a tap set into a shadow bank and swaps it
// into the active bank in one edge at a sample boundary, so taps are never mixed.
module fir_coe_loader #(
    parameter int unsigned COE_WIDTH = 16,
    parameter int unsigned COE_NUM   = 29
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic [COE_WIDTH-1:0]         cfg_tdata,
    input  logic                         cfg_tvalid,
    input  logic                         cfg_tlast,
    output logic                         cfg_tready,
    input  logic                         sample_strobe_i,
    output logic [COE_NUM*COE_WIDTH-1:0] coe_o,
    output logic                         swap_pending_o,
    output logic                         load_err_o
);

    localparam int unsigned        IDX_W    = $clog2(COE_NUM);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(COE_NUM - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitSwap,
        StDrain
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 tready_q;
    logic                 pending_q;
    logic                 err_q;
    logic [COE_WIDTH-1:0] shadow_q [COE_NUM];
    logic [COE_WIDTH-1:0] active_q [COE_NUM];
    logic                 beat;

    assign beat           = cfg_tvalid & tready_q;
    assign cfg_tready     = tready_q;
    assign swap_pending_o = pending_q;
    assign load_err_o     = err_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            tready_q  <= 1'b1;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (beat) begin
                        if (cfg_tlast) begin
                            err_q <= 1'b1;
                            idx_q <= '0;
                        end else begin
                            idx_q   <= IDX_W'(1);
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (beat) begin
                        if (cfg_tlast) begin
                            idx_q <= '0;
                            if (idx_q == IDX_LAST) begin
                                state_q   <= StWaitSwap;
                                tready_q  <= 1'b0;
                                pending_q <= 1'b1;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else if (idx_q == IDX_LAST) begin
                            // Set is full but unterminated: swallow the rest up to tlast.
                            idx_q   <= '0;
                            state_q <= StDrain;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (beat && cfg_tlast) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StWaitSwap: begin
                    if (sample_strobe_i) begin
                        state_q   <= StIdle;
                        tready_q  <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Coefficient banks carry no reset so a reset never disturbs the running filter.
    always_ff @(posedge clk_i) begin
        if (beat && (state_q == StIdle || state_q == StLoad)) begin
            shadow_q[idx_q] <= cfg_tdata;
        end
        if (state_q == StWaitSwap && sample_strobe_i) begin
            active_q <= shadow_q;
        end
    end

    for (genvar k = 0; k < COE_NUM; k++) begin : g_coe
        assign coe_o[k*COE_WIDTH +: COE_WIDTH] = active_q[k];
    end

endmodule
